// File: rtl/biu_pkg.sv
// biu_pkg: command codes, sequencer states and shared helpers for the BIU SDRAM sequencer
package biu_pkg;
  localparam logic [2:0] CMD_NOP = 3'b000;
  localparam logic [2:0] CMD_ACT = 3'b001;
  localparam logic [2:0] CMD_RD  = 3'b010;
  localparam logic [2:0] CMD_WR  = 3'b011;
  localparam logic [2:0] CMD_PRE = 3'b100;
  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_ACT      = 4'd1;
  localparam logic [3:0] S_CAS_WAIT = 4'd2;
  localparam logic [3:0] S_RW       = 4'd3;
  localparam logic [3:0] S_LAT_WAIT = 4'd4;
  localparam logic [3:0] S_BURST    = 4'd5;
  localparam logic [3:0] S_TWAIT    = 4'd6;
  localparam logic [3:0] S_PRE      = 4'd7;
  localparam logic [3:0] S_PRE_WAIT = 4'd8;
  localparam int BURST_WRAP = 8;
  function automatic logic [7:0] eff(input logic [7:0] t);
    return t == 8'd0 ? 8'd1 : t;
  endfunction
endpackage

// File: rtl/biu_down_cnt.sv
// biu_down_cnt: loadable down-counter with decrement enable and is-one flag
module biu_down_cnt #(
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          dec,
  input  logic [TW-1:0] load_val,
  output logic          is_one
);
  logic [TW-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec && cnt != '0) cnt <= cnt - TW'(1);
  assign is_one = cnt == TW'(1);
endmodule

// File: rtl/biu_sdram_seq.sv
// biu_sdram_seq: turns one accepted request into ACT -> RD/WR -> burst -> PRE using snapshotted timings
module biu_sdram_seq
  import biu_pkg::*;
#(
  parameter int AW = 30,
  parameter int CW = 10,
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          prog_mode,
  input  logic [2:0]    tburst,
  input  logic          addr_mode,
  input  logic [3:0]    tlat,
  input  logic [7:0]    tpre,
  input  logic [7:0]    twait,
  input  logic [7:0]    tcas,
  input  logic          req_valid,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  output logic          req_ready,
  output logic [2:0]    cmd,
  output logic [AW-1:0] sdr_addr,
  output logic          beat_valid,
  output logic          last_beat,
  output logic          busy
);
  localparam int WB = $clog2(BURST_WRAP);
  logic [3:0]    state, nxt;
  logic [AW-1:0] addr_q;
  logic          wr_q, am_q, accept, ld, dec, is_one;
  logic [2:0]    tb_q, beat;
  logic [3:0]    lat_q;
  logic [7:0]    pre_q, wait_q, cas_q, ecas, elat, ewait, epre;
  logic [TW-1:0] ld_val;
  logic [CW-1:0] col;
  assign ecas      = eff(cas_q);
  assign elat      = wr_q ? 8'd1 : eff({4'd0, lat_q});
  assign ewait     = eff(wait_q);
  assign epre      = eff(pre_q);
  assign req_ready = rst_n && state == S_IDLE && !prog_mode;
  assign accept    = req_valid && req_ready;
  assign busy      = state != S_IDLE;
  assign beat_valid = state == S_BURST;
  assign last_beat  = state == S_BURST && beat == tb_q;
  // Wrap mode rotates only the low bits inside the aligned BURST_WRAP block
  assign col = am_q ? {addr_q[CW-1:WB], addr_q[WB-1:0] + WB'(beat)}
                    : addr_q[CW-1:0] + CW'(beat);
  assign sdr_addr = (state == S_ACT || state == S_RW) ? addr_q
                  : state == S_BURST ? {addr_q[AW-1:CW], col} : '0;
  assign cmd = state == S_ACT ? CMD_ACT
             : state == S_RW  ? (wr_q ? CMD_WR : CMD_RD)
             : state == S_PRE ? CMD_PRE : CMD_NOP;
  biu_down_cnt #(.TW(TW)) u_cnt (
    .clk(clk), .rst_n(rst_n), .load(ld), .dec(dec), .load_val(ld_val), .is_one(is_one)
  );
  // Each phase loads E-1 so that leaving on is_one lands the next event exactly E cycles later
  always_comb begin
    nxt = state;
    ld = 1'b0;
    dec = 1'b0;
    ld_val = '0;
    case (state)
      S_IDLE: nxt = accept ? S_ACT : S_IDLE;
      S_ACT: begin
        ld = 1'b1;
        ld_val = TW'(ecas - 8'd1);
        nxt = ecas == 8'd1 ? S_RW : S_CAS_WAIT;
      end
      S_CAS_WAIT: begin
        dec = 1'b1;
        nxt = is_one ? S_RW : S_CAS_WAIT;
      end
      S_RW: begin
        ld = 1'b1;
        ld_val = TW'(elat - 8'd1);
        nxt = elat == 8'd1 ? S_BURST : S_LAT_WAIT;
      end
      S_LAT_WAIT: begin
        dec = 1'b1;
        nxt = is_one ? S_BURST : S_LAT_WAIT;
      end
      S_BURST: begin
        ld = beat == tb_q;
        ld_val = TW'(ewait - 8'd1);
        nxt = beat != tb_q ? S_BURST : ewait == 8'd1 ? S_PRE : S_TWAIT;
      end
      S_TWAIT: begin
        dec = 1'b1;
        nxt = is_one ? S_PRE : S_TWAIT;
      end
      S_PRE: begin
        ld = 1'b1;
        ld_val = TW'(epre - 8'd1);
        nxt = epre == 8'd1 ? S_IDLE : S_PRE_WAIT;
      end
      S_PRE_WAIT: begin
        dec = 1'b1;
        nxt = is_one ? S_IDLE : S_PRE_WAIT;
      end
      default: nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      beat   <= '0;
      addr_q <= '0;
      wr_q   <= 1'b0;
      am_q   <= 1'b0;
      tb_q   <= '0;
      lat_q  <= '0;
      pre_q  <= '0;
      wait_q <= '0;
      cas_q  <= '0;
    end else begin
      state <= nxt;
      beat  <= state == S_BURST ? beat + 3'd1 : 3'd0;
      if (accept) begin
        addr_q <= req_addr;
        wr_q   <= req_write;
        am_q   <= addr_mode;
        tb_q   <= tburst;
        lat_q  <= tlat;
        pre_q  <= tpre;
        wait_q <= twait;
        cas_q  <= tcas;
      end
    end
  end
endmodule

// File: tb/tb_biu_sdram_seq.sv
// tb_biu_sdram_seq: table-driven and randomized checks of the sequencer against an event-schedule model
module tb_biu_sdram_seq;
  import biu_pkg::*;
  localparam int AW = 30;
  localparam int CW = 10;
  localparam int TW = 8;
  logic          clk = 1'b0, rst_n = 1'b0, prog_mode = 1'b0, addr_mode = 1'b0;
  logic [2:0]    tburst = '0;
  logic [3:0]    tlat = '0;
  logic [7:0]    tpre = '0, twait = '0, tcas = '0;
  logic          req_valid = 1'b0, req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic          req_ready, beat_valid, last_beat, busy;
  logic [2:0]    cmd;
  logic [AW-1:0] sdr_addr;
  int n_chk = 0, n_fail = 0;
  typedef struct {
    bit w; logic [AW-1:0] addr; bit [2:0] tb; bit am; bit [3:0] lat;
    bit [7:0] pre, wt, cas; int rw, b0, pr, rdy, c_first, c_last;
  } vec_t;
  biu_sdram_seq #(.AW(AW), .CW(CW), .TW(TW)) dut (
    .clk(clk), .rst_n(rst_n), .prog_mode(prog_mode), .tburst(tburst), .addr_mode(addr_mode),
    .tlat(tlat), .tpre(tpre), .twait(twait), .tcas(tcas), .req_valid(req_valid),
    .req_write(req_write), .req_addr(req_addr), .req_ready(req_ready), .cmd(cmd),
    .sdr_addr(sdr_addr), .beat_valid(beat_valid), .last_beat(last_beat), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [AW-1:0] exp_addr(input logic [AW-1:0] a, input bit am, input int i);
    int unsigned col0, col, upper;
    col0  = int'(a) & 32'h3FF;
    upper = int'(a) >> CW;
    col   = am ? ((col0 & ~32'h7) | ((col0 + i) & 32'h7)) : ((col0 + i) & 32'h3FF);
    return AW'((upper << CW) | col);
  endfunction
  task automatic wait_idle(input string name);
    int k = 0;
    while (busy && k < 300) begin
      @(negedge clk);
      k++;
    end
    check(name, busy, 0);
  endtask
  task automatic run_txn(input vec_t v, output int o_rw, output int o_b0, output int o_pr,
                         output int o_rdy, output int o_cf, output int o_cl);
    int ecas, elat, ewait, epre, trw, tb0, tl, tp, tr;
    logic [2:0] ecmd;
    ecas  = v.cas == 0 ? 1 : int'(v.cas);
    elat  = v.w ? 1 : (v.lat == 0 ? 1 : int'(v.lat));
    ewait = v.wt == 0 ? 1 : int'(v.wt);
    epre  = v.pre == 0 ? 1 : int'(v.pre);
    trw = ecas;
    tb0 = trw + elat;
    tl  = tb0 + int'(v.tb);
    tp  = tl + ewait;
    tr  = tp + epre;
    {o_rw, o_b0, o_pr, o_rdy, o_cf, o_cl} = {-1, -1, -1, -1, -1, -1};
    @(negedge clk);
    {req_write, req_addr, tburst, addr_mode, tlat, tpre, twait, tcas} =
      {v.w, v.addr, v.tb, v.am, v.lat, v.pre, v.wt, v.cas};
    req_valid = 1'b1;
    check("ready_at_request", req_ready, 1);
    @(negedge clk);
    for (int t = 0; t <= tr; t++) begin
      if (t > 0) @(negedge clk);
      ecmd = t == 0 ? CMD_ACT : t == trw ? (v.w ? CMD_WR : CMD_RD) : t == tp ? CMD_PRE : CMD_NOP;
      check($sformatf("ctl t=%0d", t), {cmd, beat_valid, last_beat, busy, req_ready},
            {ecmd, t >= tb0 && t <= tl, t == tl, t < tr, t == tr});
      if (t == 0 || t == trw) check($sformatf("cmd_addr t=%0d", t), sdr_addr, v.addr);
      if (t >= tb0 && t <= tl)
        check($sformatf("beat_addr t=%0d", t), sdr_addr, exp_addr(v.addr, v.am, t - tb0));
      if ((cmd == CMD_RD || cmd == CMD_WR) && o_rw < 0) o_rw = t;
      if (beat_valid && o_b0 < 0) begin
        o_b0 = t;
        o_cf = int'(sdr_addr[CW-1:0]);
      end
      if (last_beat) o_cl = int'(sdr_addr[CW-1:0]);
      if (cmd == CMD_PRE && o_pr < 0) o_pr = t;
      if (req_ready && o_rdy < 0) o_rdy = t;
      // Scramble everything the snapshot must ignore; tcas jumps to 9 right after acceptance
      tcas = t == 0 ? 8'd9 : 8'($urandom);
      {tlat, tpre, twait, tburst, addr_mode} = {4'($urandom), 8'($urandom), 8'($urandom), 3'($urandom), 1'($urandom)};
      req_write = 1'($urandom);
      req_addr  = AW'($urandom);
      req_valid = t < tr ? 1'($urandom) : 1'b0;
    end
    req_valid = 1'b0;
  endtask
  initial begin
    vec_t tbl[6];
    vec_t v;
    int o_rw, o_b0, o_pr, o_rdy, o_cf, o_cl;
    tbl[0] = '{0, 30'h5,        3, 0,  2, 4, 2, 3, 3,  5, 10, 14, 'h5,   'h8};
    tbl[1] = '{1, 30'h048D17FD, 7, 1,  5, 1, 1, 2, 2,  3, 11, 12, 'h3FD, 'h3FC};
    tbl[2] = '{1, 30'h3FF0,     0, 0,  0, 0, 0, 0, 1,  2,  3,  4, 'h3F0, 'h3F0};
    tbl[3] = '{0, 30'h2AAAA,    0, 1,  0, 0, 0, 0, 1,  2,  3,  4, 'h2AA, 'h2AA};
    tbl[4] = '{0, 30'h1FFFFFFE, 3, 0,  1, 0, 0, 1, 1,  2,  6,  7, 'h3FE, 'h001};
    tbl[5] = '{0, 30'h0ABCD405, 7, 1, 15, 2, 3, 0, 1, 16, 26, 28, 'h005, 'h004};
    #12;
    check("rst_ctl", {cmd, beat_valid, last_beat, busy, req_ready}, 0);
    check("rst_addr", sdr_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", req_ready, 1);
    for (int i = 0; i < 6; i++) begin
      run_txn(tbl[i], o_rw, o_b0, o_pr, o_rdy, o_cf, o_cl);
      check($sformatf("vec%0d rw_time", i), o_rw, tbl[i].rw);
      check($sformatf("vec%0d beat0_time", i), o_b0, tbl[i].b0);
      check($sformatf("vec%0d pre_time", i), o_pr, tbl[i].pr);
      check($sformatf("vec%0d ready_time", i), o_rdy, tbl[i].rdy);
      check($sformatf("vec%0d first_col", i), o_cf, tbl[i].c_first);
      check($sformatf("vec%0d last_col", i), o_cl, tbl[i].c_last);
      wait_idle("vec_settle");
    end
    @(negedge clk);
    {tcas, tlat, twait, tpre, tburst, req_write, req_addr} = '0;
    prog_mode = 1'b1;
    req_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("prog_ready", req_ready, 0);
      check("prog_no_act", cmd, CMD_NOP);
    end
    prog_mode = 1'b0;
    #1 check("prog_drop_ready", req_ready, 1);
    @(negedge clk);
    check("prog_drop_act", cmd, CMD_ACT);
    req_valid = 1'b0;
    wait_idle("prog_settle");
    @(negedge clk);
    {tcas, tlat, tburst, req_write, req_addr} = {8'd1, 4'd1, 3'd7, 1'b0, 30'h123};
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("burst_before_reset", {beat_valid, sdr_addr}, {1'b1, 30'h125});
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_ctl", {cmd, beat_valid, last_beat, busy, req_ready}, 0);
    check("async_rst_addr", sdr_addr, 0);
    @(negedge clk);
    check("held_rst_cmd", cmd, CMD_NOP);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_release", {req_ready, busy, cmd}, {1'b1, 1'b0, CMD_NOP});
    for (int n = 0; n < 40; n++) begin
      v.w = 1'($urandom);
      v.addr = AW'($urandom);
      v.tb = 3'($urandom);
      v.am = 1'($urandom);
      v.lat = 4'($urandom_range(0, 6));
      v.pre = 8'($urandom_range(0, n % 8 == 0 ? 40 : 5));
      v.wt  = 8'($urandom_range(0, 5));
      v.cas = 8'($urandom_range(0, n % 8 == 1 ? 40 : 5));
      run_txn(v, o_rw, o_b0, o_pr, o_rdy, o_cf, o_cl);
      wait_idle("rand_settle");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
